// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage: forwarding muxes, ALU, branch resolve, EX/MEM reg.
//            Define EX_MUL_EN to include the iterative shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int PC_WIDTH      = 12,
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [1:0]               ex_alu_op,
    input  logic                     ex_alu_src,
    input  logic                     ex_branch,
    input  logic [PC_WIDTH-1:0]      ex_pc,
    input  logic [DATA_WIDTH-1:0]    ex_read_data1,
    input  logic [DATA_WIDTH-1:0]    ex_read_data2,
    input  logic [DATA_WIDTH-1:0]    ex_imm,
    input  logic [REGADDR_WIDTH-1:0] ex_rd,
    input  logic [1:0]               fwd_a,
    input  logic [1:0]               fwd_b,
    input  logic [DATA_WIDTH-1:0]    mem_fwd_data,
    input  logic [DATA_WIDTH-1:0]    wb_fwd_data,
    output logic                     ex_stall,
    output logic                     branch_taken,
    output logic [PC_WIDTH-1:0]      branch_target,
    output logic                     mem_reg_write,
    output logic                     mem_mem_read,
    output logic                     mem_mem_write,
    output logic [DATA_WIDTH-1:0]    mem_alu_result,
    output logic [DATA_WIDTH-1:0]    mem_store_data,
    output logic [REGADDR_WIDTH-1:0] mem_rd
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_bf;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [DATA_WIDTH-1:0]    alu_res;
    logic                     slt;
    logic                     mul_active;
    logic                     stall_req;

    logic                     reg_write_d,  reg_write_q;
    logic                     mem_read_d,   mem_read_q;
    logic                     mem_write_d,  mem_write_q;
    logic [DATA_WIDTH-1:0]    alu_result_d, alu_result_q;
    logic [DATA_WIDTH-1:0]    store_data_d, store_data_q;
    logic [REGADDR_WIDTH-1:0] rd_d,         rd_q;

    always_comb begin
        case (fwd_a)
            2'b01:   op_a = mem_fwd_data;
            2'b10:   op_a = wb_fwd_data;
            default: op_a = ex_read_data1;
        endcase
        case (fwd_b)
            2'b01:   op_bf = mem_fwd_data;
            2'b10:   op_bf = wb_fwd_data;
            default: op_bf = ex_read_data2;
        endcase
    end

    assign op_b = ex_alu_src ? ex_imm : op_bf;
    assign slt  = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        case (ex_alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (ex_imm[2:0])
                    3'b000:  alu_res = op_a + op_b;
                    3'b001:  alu_res = op_a - op_b;
                    3'b010:  alu_res = op_a & op_b;
                    3'b011:  alu_res = op_a | op_b;
                    3'b100:  alu_res = op_a ^ op_b;
                    3'b101:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt};
                    3'b110:  alu_res = op_a << op_b[SHW-1:0];
                    default: alu_res = '0;  // MUL result comes from the FSM when present
                endcase
            end
            default: alu_res = op_b;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         count_q;
    logic [DATA_WIDTH-1:0]    mcand_q;
    logic [DATA_WIDTH-1:0]    mplier_q;
    logic [DATA_WIDTH-1:0]    acc_q;
    logic                     mul_reg_write_q;
    logic                     mul_mem_read_q;
    logic                     mul_mem_write_q;
    logic [REGADDR_WIDTH-1:0] mul_rd_q;
    logic                     is_mul;

    assign is_mul     = (ex_alu_op == 2'b10) && (ex_imm[2:0] == 3'b111);
    assign mul_active = (state_q != S_IDLE);
    assign stall_req  = (state_q == S_BUSY) || ((state_q == S_IDLE) && is_mul);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            count_q         <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            acc_q           <= '0;
            mul_reg_write_q <= 1'b0;
            mul_mem_read_q  <= 1'b0;
            mul_mem_write_q <= 1'b0;
            mul_rd_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand_q         <= op_a;
                        mplier_q        <= op_b;
                        acc_q           <= '0;
                        count_q         <= CNT_W'(DATA_WIDTH);
                        mul_reg_write_q <= ex_reg_write;
                        mul_mem_read_q  <= ex_mem_read;
                        mul_mem_write_q <= ex_mem_write;
                        mul_rd_q        <= ex_rd;
                        state_q         <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mcand_q[0]) begin
                        acc_q <= acc_q + mplier_q;
                    end
                    mcand_q  <= mcand_q >> 1;
                    mplier_q <= mplier_q << 1;
                    count_q  <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign mul_active = 1'b0;
    assign stall_req  = 1'b0;
`endif

    assign ex_stall      = reset_n & stall_req;
    assign branch_taken  = ex_branch & (op_a == op_bf) & ~mul_active;
    assign branch_target = ex_pc + ex_imm[PC_WIDTH-1:0];

    // Branches and multiplier stall cycles enter EX/MEM as bubbles.
    always_comb begin
        reg_write_d  = ex_reg_write & ~ex_branch & ~stall_req;
        mem_read_d   = ex_mem_read  & ~ex_branch & ~stall_req;
        mem_write_d  = ex_mem_write & ~ex_branch & ~stall_req;
        alu_result_d = alu_res;
        store_data_d = op_bf;
        rd_d         = ex_rd;
`ifdef EX_MUL_EN
        if (state_q == S_DONE) begin
            reg_write_d  = mul_reg_write_q;
            mem_read_d   = mul_mem_read_q;
            mem_write_d  = mul_mem_write_q;
            alu_result_d = acc_q;
            store_data_d = '0;
            rd_d         = mul_rd_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
        end
    end

    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_alu_result = alu_result_q;
    assign mem_store_data = store_data_q;
    assign mem_rd         = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Scoreboard bench for ex_stage; expectations follow EX_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    localparam int PW = 12;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          reset_n;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]    ex_alu_op;
    logic          ex_alu_src, ex_branch;
    logic [PW-1:0] ex_pc;
    logic [DW-1:0] ex_read_data1, ex_read_data2, ex_imm;
    logic [AW-1:0] ex_rd;
    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] mem_fwd_data, wb_fwd_data;
    logic          ex_stall, branch_taken;
    logic [PW-1:0] branch_target;
    logic          mem_reg_write, mem_mem_read, mem_mem_write;
    logic [DW-1:0] mem_alu_result, mem_store_data;
    logic [AW-1:0] mem_rd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic          rw;
        logic          mr;
        logic          mw;
        logic [DW-1:0] res;
        logic [DW-1:0] st;
        logic [AW-1:0] rd;
        logic          chk_data;
        logic          chk_st;
    } exp_t;

    exp_t sb[$];

    ex_stage #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .REGADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_pc(ex_pc), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .ex_stall(ex_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] rf);
        case (sel)
            2'b01:   return mem_fwd_data;
            2'b10:   return wb_fwd_data;
            default: return rf;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [2:0] f,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return b;
            default: begin
                case (f)
                    3'd0: return a + b;
                    3'd1: return a - b;
                    3'd2: return a & b;
                    3'd3: return a | b;
                    3'd4: return a ^ b;
                    3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                    3'd6: return a << b[3:0];
`ifdef EX_MUL_EN
                    default: return a * b;
`else
                    default: return 16'd0;
`endif
                endcase
            end
        endcase
    endfunction

    task automatic idle_inputs();
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_alu_op = 2'b00; ex_alu_src = 0; ex_branch = 0;
        ex_pc = '0; ex_read_data1 = '0; ex_read_data2 = '0; ex_imm = '0; ex_rd = '0;
        fwd_a = 2'b00; fwd_b = 2'b00; mem_fwd_data = '0; wb_fwd_data = '0;
    endtask

    task automatic load(input logic [1:0] op, input logic src, input logic [DW-1:0] imm,
                        input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [AW-1:0] rd);
        idle_inputs();
        ex_reg_write = 1; ex_alu_op = op; ex_alu_src = src; ex_imm = imm;
        ex_read_data1 = r1; ex_read_data2 = r2; fwd_a = fa; fwd_b = fb; ex_rd = rd;
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_underflow: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        chk("ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, {29'd0, e.rw, e.mr, e.mw});
        if (e.chk_data) begin
            chk("result", mem_alu_result, e.res);
            chk("rd", mem_rd, e.rd);
        end
        if (e.chk_st) chk("store", mem_store_data, e.st);
    endtask

    // One single-cycle instruction: called just after a rising edge with inputs set.
    task automatic step_alu();
        logic [DW-1:0] a, bf, b;
        logic [PW-1:0] tgt;
        exp_t e;
        a  = fwd(fwd_a, ex_read_data1);
        bf = fwd(fwd_b, ex_read_data2);
        b  = ex_alu_src ? ex_imm : bf;
        tgt = ex_pc + ex_imm[PW-1:0];
        e.rw = ex_reg_write & ~ex_branch;
        e.mr = ex_mem_read  & ~ex_branch;
        e.mw = ex_mem_write & ~ex_branch;
        e.res = ref_alu(ex_alu_op, ex_imm[2:0], a, b);
        e.st = bf;
        e.rd = ex_rd;
        e.chk_data = ~ex_branch;
        e.chk_st = ~ex_branch;
        @(negedge clk);
        chk("stall", {31'd0, ex_stall}, 32'd0);
        chk("taken", {31'd0, branch_taken}, {31'd0, ex_branch & (a == bf)});
        if (ex_branch) chk("target", {20'd0, branch_target}, {20'd0, tgt});
        sb.push_back(e);
        @(posedge clk); #1;
        pop_cmp();
    endtask

`ifdef EX_MUL_EN
    // Multiply: 17 stalled cycles of bubbles, then the product on the DONE edge.
    task automatic run_mul();
        logic [DW-1:0] a, b;
        exp_t fin, bub;
        a = fwd(fwd_a, ex_read_data1);
        b = ex_alu_src ? ex_imm : fwd(fwd_b, ex_read_data2);
        fin = '0;
        fin.rw = ex_reg_write; fin.mr = ex_mem_read; fin.mw = ex_mem_write;
        fin.res = a * b; fin.rd = ex_rd; fin.chk_data = 1;
        bub = '0;
        for (int c = 0; c < DW + 2; c++) begin
            @(negedge clk);
            chk("mul_stall", {31'd0, ex_stall}, (c < DW + 1) ? 32'd1 : 32'd0);
            chk("mul_taken", {31'd0, branch_taken}, 32'd0);
            if (c == 3) begin
                mem_fwd_data = 16'hDEAD;
                wb_fwd_data  = 16'hBEEF;
            end
            sb.push_back((c < DW + 1) ? bub : fin);
            @(posedge clk); #1;
            pop_cmp();
        end
    endtask
`endif

    initial begin
        idle_inputs();
        reset_n = 0;
        ex_alu_op = 2'b10; ex_imm = 16'h0007; ex_reg_write = 1;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, ex_stall}, 32'd0);
        chk("rst_ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
        chk("rst_res", mem_alu_result, 32'd0);
        chk("rst_store", mem_store_data, 32'd0);
        chk("rst_rd", mem_rd, 32'd0);
        idle_inputs();
        reset_n = 1;
        @(posedge clk); #1;

        load(2'b10, 0, 16'h0000, 16'h7FFF, 16'h0001, 2'b00, 2'b00, 3'd1); step_alu();
        load(2'b10, 0, 16'h0005, 16'hFFFF, 16'h0001, 2'b00, 2'b00, 3'd2); step_alu();
        load(2'b10, 0, 16'h0005, 16'h0001, 16'hFFFF, 2'b00, 2'b00, 3'd2); step_alu();
        load(2'b00, 1, 16'h0001, 16'h0000, 16'h0000, 2'b01, 2'b00, 3'd4);
        mem_fwd_data = 16'h0042; step_alu();
        load(2'b01, 0, 16'h0000, 16'h0000, 16'h0001, 2'b00, 2'b00, 3'd5); step_alu();
        load(2'b10, 0, 16'h0006, 16'h0001, 16'h001F, 2'b00, 2'b00, 3'd6); step_alu();
        load(2'b11, 0, 16'h1111, 16'h0000, 16'h2222, 2'b00, 2'b10, 3'd7);
        wb_fwd_data = 16'hBEEF; ex_mem_write = 1; step_alu();
        load(2'b00, 0, 16'h0000, 16'h1000, 16'h0234, 2'b11, 2'b11, 3'd3);
        mem_fwd_data = 16'hFFFF; wb_fwd_data = 16'hFFFF; ex_mem_read = 1; step_alu();

        load(2'b01, 1, 16'h0020, 16'h0005, 16'h0005, 2'b00, 2'b00, 3'd1);
        ex_branch = 1; ex_pc = 12'hFF0; ex_mem_write = 1; step_alu();
        load(2'b01, 1, 16'h0020, 16'h0020, 16'h0005, 2'b00, 2'b00, 3'd1);
        ex_branch = 1; ex_pc = 12'h100; step_alu();

        for (int i = 0; i < 40; i++) begin
            idle_inputs();
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_mem_write = 1'($urandom_range(0, 1));
            ex_alu_op    = 2'($urandom_range(0, 3));
            ex_alu_src   = 1'($urandom_range(0, 1));
            ex_imm       = 16'($urandom);
            ex_pc        = 12'($urandom);
            ex_read_data1 = 16'($urandom);
            ex_read_data2 = 16'($urandom);
            mem_fwd_data = 16'($urandom);
            wb_fwd_data  = 16'($urandom);
            fwd_a = 2'($urandom_range(0, 3));
            fwd_b = 2'($urandom_range(0, 3));
            ex_rd = 3'($urandom_range(0, 7));
            if (ex_alu_op == 2'b10 && ex_imm[2:0] == 3'b111) ex_imm[2:0] = 3'b110;
            if ($urandom_range(0, 3) == 0) begin
                ex_branch = 1;
                if ($urandom_range(0, 1) == 1) begin
                    fwd_a = 2'b00; fwd_b = 2'b00; ex_read_data2 = ex_read_data1;
                end
            end
            step_alu();
        end

        load(2'b10, 0, 16'h0007, 16'h0000, 16'h0005, 2'b01, 2'b00, 3'd6);
        mem_fwd_data = 16'h0003;
`ifdef EX_MUL_EN
        run_mul();
        load(2'b10, 1, 16'h0FF7, 16'h1234, 16'h0000, 2'b00, 2'b00, 3'd2);
        ex_mem_read = 1; run_mul();
`else
        step_alu();
        load(2'b10, 1, 16'h0FF7, 16'h1234, 16'h0000, 2'b00, 2'b00, 3'd2);
        step_alu();
`endif

        // Asynchronous reset in the middle of a multiply, then an ADD straight after release.
        load(2'b10, 0, 16'h0007, 16'h0003, 16'h0005, 2'b00, 2'b00, 3'd5);
        ex_mem_write = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("midrst_stall", {31'd0, ex_stall}, 32'd0);
        chk("midrst_ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
        chk("midrst_res", mem_alu_result, 32'd0);
        chk("midrst_rd", mem_rd, 32'd0);
        @(posedge clk); #1;
        chk("midrst_hold", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
        @(negedge clk);
        load(2'b00, 0, 16'h0000, 16'h0100, 16'h0023, 2'b00, 2'b00, 3'd3);
        reset_n = 1;
        @(posedge clk); #1;
        chk("postrst_res", mem_alu_result, 32'h0123);
        chk("postrst_rw", {31'd0, mem_reg_write}, 32'd1);
        chk("postrst_rd", mem_rd, 32'd3);

        idle_inputs();
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
